// File: rtl/timx_apb_cmd_master_pkg.sv
// Shared types for the timx APB command master.
// Bus widths, FSM state and the buffered command record.
package timx_apb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/timx_apb_cmd_master_if.sv
// Command stream, response stream and APB bus of the master.
// master = the APB initiator side, slave = its environment.
interface timx_apb_cmd_master_if;
  import timx_apb_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              busy;

  logic              timx_psel;
  logic              timx_penable;
  logic              timx_pwrite;
  logic [ADDR_W-1:0] timx_paddr;
  logic [DATA_W-1:0] timx_pwdata;
  logic [DATA_W-1:0] timx_prdata;
  logic              timx_pready;
  logic              timx_pslverr;

  modport master (
    input  cmd_valid, cmd_write,
    input  cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata,
    output rsp_err, rsp_timeout,
    input  rsp_ready,
    output busy,
    output timx_psel, timx_penable,
    output timx_pwrite, timx_paddr,
    output timx_pwdata,
    input  timx_prdata, timx_pready,
    input  timx_pslverr
  );

  modport slave (
    output cmd_valid, cmd_write,
    output cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata,
    input  rsp_err, rsp_timeout,
    output rsp_ready,
    input  busy,
    input  timx_psel, timx_penable,
    input  timx_pwrite, timx_paddr,
    input  timx_pwdata,
    output timx_prdata, timx_pready,
    output timx_pslverr
  );

endinterface

// File: rtl/timx_apb_cmd_master_fifo.sv
// Synchronous command FIFO, power-of-2 depth.
// Pointers wrap naturally; head is the oldest entry.
module timx_apb_cmd_fifo
  import timx_apb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  apb_cmd_t din,
  output logic     full,
  output logic     empty,
  output apb_cmd_t head
);

  localparam int PW = $clog2(DEPTH);

  apb_cmd_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_q;
  logic [PW-1:0]   rd_q;
  logic [PW:0]     cnt_q;
  logic            wr_en;
  logic            rd_en;

  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem_q[rd_q];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // storage needs no reset; validity lives in cnt_q
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/timx_apb_cmd_master.sv
// APB3 initiator: buffered commands in, in-order responses out.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module timx_apb_cmd_master
  import timx_apb_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   apb_clk,
  input  logic                   apb_rst_n,
  timx_apb_cmd_master_if.master  bus
);

  apb_state_t        state_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              slot_free;
  logic              expire;
  apb_cmd_t          cmd_in;
  apb_cmd_t          head;

  assign cmd_in    = '{write: bus.cmd_write,
                       addr:  bus.cmd_addr,
                       wdata: bus.cmd_wdata};
  assign push      = bus.cmd_valid && !full;
  assign slot_free = !rsp_valid_q || bus.rsp_ready;
  assign pop       = (state_q == IDLE) && !empty
                     && slot_free;

  timx_apb_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (apb_clk),
    .rst_n (apb_rst_n),
    .push  (push),
    .pop   (pop),
    .din   (cmd_in),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt_q;
  logic          tmo_q;

  assign expire = (state_q == ACCESS)
                  && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign bus.rsp_timeout = tmo_q;

  // counts ACCESS cycles without pready
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      tcnt_q <= '0;
    end else if (pop) begin
      tcnt_q <= '0;
    end else if (state_q == ACCESS
                 && !bus.timx_pready && !expire) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end
`else
  assign expire          = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  // transfer FSM with registered APB and response outputs
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_q       <= 1'b0;
`endif
    end else begin
      if (rsp_valid_q && bus.rsp_ready)
        rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q  <= SETUP;
            psel_q   <= 1'b1;
            pwrite_q <= head.write;
            paddr_q  <= head.addr;
            pwdata_q <= head.wdata;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (bus.timx_pready) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= pwrite_q ? '0
                           : bus.timx_prdata;
            err_q       <= bus.timx_pslverr;
`ifdef APB_TIMEOUT_EN
            tmo_q       <= 1'b0;
`endif
          end else if (expire) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= '0;
            err_q       <= 1'b1;
`ifdef APB_TIMEOUT_EN
            tmo_q       <= 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = !full;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_err      = err_q;
  assign bus.busy         = !empty || (state_q != IDLE)
                            || rsp_valid_q;
  assign bus.timx_psel    = psel_q;
  assign bus.timx_penable = penable_q;
  assign bus.timx_pwrite  = pwrite_q;
  assign bus.timx_paddr   = paddr_q;
  assign bus.timx_pwdata  = pwdata_q;

endmodule

// File: tb/tb_timx_apb_cmd_master.sv
// Bench for timx_apb_cmd_master: directed + random traffic.
// Timeout checks depend on APB_TIMEOUT_EN.
module tb_timx_apb_cmd_master;
  import timx_apb_pkg::*;

  localparam int TMO = 16;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
  } cmd_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } rsp_t;

  logic apb_clk = 1'b0;
  logic apb_rst_n = 1'b0;

  timx_apb_cmd_master_if bus();

  timx_apb_cmd_master #(
    .CMD_DEPTH      (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .apb_clk   (apb_clk),
    .apb_rst_n (apb_rst_n),
    .bus       (bus)
  );

  always #5 apb_clk = ~apb_clk;

  int          nchk = 0;
  int          nerr = 0;
  bit          sb_en = 0;
  bit          slv_rand = 0;
  bit          slv_stuck = 0;
  int          slv_wait = 0;
  int          cur_wait = 0;
  int          wcnt = 0;
  int          push_cnt = 0;
  int          rsp_cnt = 0;
  logic [15:0] err_addr = 16'hFFFF;
  logic [31:0] smem [256];
  logic [31:0] rmem [256];
  cmd_t        qc [$];
  rsp_t        qr [$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic bit slv_err(input logic [15:0] a);
    return (a == err_addr) || (a[15:8] != 8'h00);
  endfunction

  // APB slave model plus in-order scoreboard
  always @(negedge apb_clk) begin : mon
    cmd_t c;
    rsp_t r;
    bit   rdy;
    bit   er;
    if (!apb_rst_n) begin
      bus.timx_pready  = 1'b0;
      bus.timx_pslverr = 1'b0;
      bus.timx_prdata  = '0;
      wcnt = 0;
    end else begin
      if (bus.timx_psel && bus.timx_penable) begin
        if (wcnt == 0)
          cur_wait = slv_rand ? $urandom_range(0, 3)
                              : slv_wait;
        rdy = !slv_stuck && (wcnt >= cur_wait);
        er  = slv_err(bus.timx_paddr);
        bus.timx_pready  = rdy;
        bus.timx_pslverr = rdy && er;
        if (rdy && !bus.timx_pwrite)
          bus.timx_prdata = er ? 32'h0
                          : smem[bus.timx_paddr[7:0]];
        else
          bus.timx_prdata = $urandom;
        if (rdy) begin
          if (sb_en) begin
            check("apb_pending", 32'(qc.size() != 0), 32'(1));
            if (qc.size() != 0) begin
              c = qc.pop_front();
              check("apb_pwrite", 32'(bus.timx_pwrite),
                    32'(c.w));
              check("apb_paddr", 32'(bus.timx_paddr),
                    32'(c.a));
              if (c.w)
                check("apb_pwdata", bus.timx_pwdata, c.d);
            end
          end
          if (bus.timx_pwrite && !er)
            smem[bus.timx_paddr[7:0]] = bus.timx_pwdata;
        end
        wcnt++;
      end else begin
        bus.timx_pready  = 1'b0;
        bus.timx_pslverr = 1'b0;
        bus.timx_prdata  = $urandom;
        wcnt = 0;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_cnt++;
        if (sb_en) begin
          check("rsp_pending", 32'(qr.size() != 0), 32'(1));
          if (qr.size() != 0) begin
            r = qr.pop_front();
            check("rsp_rdata", bus.rsp_rdata, r.rd);
            check("rsp_err", 32'(bus.rsp_err), 32'(r.err));
            check("rsp_timeout", 32'(bus.rsp_timeout), 32'(0));
          end
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        push_cnt++;
        if (sb_en) begin
          c.w = bus.cmd_write;
          c.a = bus.cmd_addr;
          c.d = bus.cmd_wdata;
          qc.push_back(c);
          er = slv_err(c.a);
          r.err = er;
          r.rd  = (c.w || er) ? 32'h0 : rmem[c.a[7:0]];
          if (c.w && !er) rmem[c.a[7:0]] = c.d;
          qr.push_back(r);
        end
      end
    end
  end

  task automatic tick();
    @(posedge apb_clk);
    #2;
  endtask

  task automatic send(input logic w,
                      input logic [15:0] a,
                      input logic [31:0] d);
    bit acc;
    acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge apb_clk);
      acc = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("send_accept", 32'(acc), 32'(1));
  endtask

  task automatic get_rsp(output logic [31:0] rd,
                         output logic er,
                         output logic tm);
    int k;
    k = 0;
    @(negedge apb_clk);
    while (!bus.rsp_valid && k < 300) begin
      @(negedge apb_clk);
      k++;
    end
    check("rsp_wait", 32'(bus.rsp_valid), 32'(1));
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    tm = bus.rsp_timeout;
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    @(negedge apb_clk);
    while (bus.busy && k < bound) begin
      @(negedge apb_clk);
      k++;
    end
    check("drain_busy", 32'(bus.busy), 32'(0));
    check("drain_sb", 32'(qr.size() + qc.size()), 32'(0));
    tick();
  endtask

  task automatic wait_penable();
    int k;
    k = 0;
    @(negedge apb_clk);
    while (!bus.timx_penable && k < 40) begin
      @(negedge apb_clk);
      k++;
    end
    check("penable_wait", 32'(bus.timx_penable), 32'(1));
  endtask

  initial begin
    cmd_t        t4 [6];
    logic [31:0] rd;
    logic [31:0] orig18;
    logic        er;
    logic        tm;
    int          n;
    int          idx;
    int          cyc;
    int          base;
    bit          acc;
    bit          saw;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      smem[i] = $urandom;
      rmem[i] = smem[i];
    end

    // reset state
    repeat (3) @(negedge apb_clk);
    check("rst_psel", 32'(bus.timx_psel), 32'(0));
    check("rst_penable", 32'(bus.timx_penable), 32'(0));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    tick();
    apb_rst_n = 1'b1;
    tick();
    @(negedge apb_clk);
    check("post_rst_ready", 32'(bus.cmd_ready), 32'(1));
    tick();
    sb_en = 1'b1;

    // single write, zero-wait latency
    send(1'b1, 16'h002C, 32'h0000FFFF);
    @(negedge apb_clk);
    check("t2_psel_n", 32'(bus.timx_psel), 32'(0));
    tick();
    @(negedge apb_clk);
    check("t2_psel_n1", 32'(bus.timx_psel), 32'(1));
    check("t2_pen_n1", 32'(bus.timx_penable), 32'(0));
    check("t2_paddr", 32'(bus.timx_paddr), 32'h002C);
    check("t2_pwdata", bus.timx_pwdata, 32'h0000FFFF);
    check("t2_pwrite", 32'(bus.timx_pwrite), 32'(1));
    tick();
    @(negedge apb_clk);
    check("t2_pen_n2", 32'(bus.timx_penable), 32'(1));
    check("t2_rspv_n2", 32'(bus.rsp_valid), 32'(0));
    tick();
    @(negedge apb_clk);
    check("t2_rspv_n3", 32'(bus.rsp_valid), 32'(1));
    check("t2_psel_n3", 32'(bus.timx_psel), 32'(0));
    check("t2_err", 32'(bus.rsp_err), 32'(0));
    check("t2_rdata", bus.rsp_rdata, 32'h0);
    tick();

    // read with 5 wait states
    smem[8'h34] = 32'h00001234;
    rmem[8'h34] = 32'h00001234;
    slv_wait = 5;
    send(1'b0, 16'h0034, 32'hDEADBEEF);
    wait_penable();
    n = 0;
    while (bus.timx_penable && n < 50) begin
      check("t3_paddr", 32'(bus.timx_paddr), 32'h0034);
      n++;
      @(negedge apb_clk);
    end
    check("t3_access_cycles", 32'(n), 32'(6));
    check("t3_rspv", 32'(bus.rsp_valid), 32'(1));
    check("t3_rdata", bus.rsp_rdata, 32'h00001234);
    tick();
    slv_wait = 0;

    // back-pressure fills FIFO, then in-order drain
    t4[0] = '{1'b1, 16'h002C, 32'h11112C2C};
    t4[1] = '{1'b0, 16'h0018, 32'h0};
    t4[2] = '{1'b1, 16'h0020, 32'h22220020};
    t4[3] = '{1'b0, 16'h000C, 32'h0};
    t4[4] = '{1'b1, 16'h0000, 32'h33330000};
    t4[5] = '{1'b0, 16'h0034, 32'h0};
    base = rsp_cnt;
    bus.rsp_ready = 1'b0;
    idx = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = t4[0].w;
    bus.cmd_addr  = t4[0].a;
    bus.cmd_wdata = t4[0].d;
    for (int ph = 0; ph < 2; ph++) begin
      cyc = 0;
      while (idx < 6 && cyc < 30) begin
        @(negedge apb_clk);
        acc = bus.cmd_ready;
        tick();
        cyc++;
        if (acc) begin
          idx++;
          if (idx < 6) begin
            bus.cmd_write = t4[idx].w;
            bus.cmd_addr  = t4[idx].a;
            bus.cmd_wdata = t4[idx].d;
          end else begin
            bus.cmd_valid = 1'b0;
          end
        end
      end
      if (ph == 0) begin
        check("t4_accepted", 32'(idx), 32'(5));
        @(negedge apb_clk);
        check("t4_cmd_ready", 32'(bus.cmd_ready), 32'(0));
        check("t4_rspv_held", 32'(bus.rsp_valid), 32'(1));
        tick();
        bus.rsp_ready = 1'b1;
      end
    end
    check("t4_all_accepted", 32'(idx), 32'(6));
    drain(100);
    check("t4_rsp_count", 32'(rsp_cnt - base), 32'(6));

    // slave error, then a normal read
    bus.rsp_ready = 1'b0;
    orig18 = smem[8'h18];
    err_addr = 16'h0018;
    send(1'b1, 16'h0018, 32'h5A5A5A5A);
    get_rsp(rd, er, tm);
    check("t5_err", 32'(er), 32'(1));
    check("t5_tmo", 32'(tm), 32'(0));
    err_addr = 16'hFFFF;
    send(1'b0, 16'h0018, 32'h0);
    get_rsp(rd, er, tm);
    check("t5_next_err", 32'(er), 32'(0));
    check("t5_next_rdata", rd, orig18);
    send(1'b0, 16'h002C, 32'h0);
    get_rsp(rd, er, tm);
    check("t5_rd2c", rd, 32'h11112C2C);
    bus.rsp_ready = 1'b1;
    drain(50);

    // reset during ACCESS
    sb_en = 1'b0;
    slv_stuck = 1'b1;
    send(1'b0, 16'h0010, 32'h0);
    wait_penable();
    tick();
    apb_rst_n = 1'b0;
    #1;
    check("t1_rst_psel", 32'(bus.timx_psel), 32'(0));
    check("t1_rst_pen", 32'(bus.timx_penable), 32'(0));
    check("t1_rst_busy", 32'(bus.busy), 32'(0));
    qc.delete();
    qr.delete();
    tick();
    tick();
    apb_rst_n = 1'b1;
    slv_stuck = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      @(negedge apb_clk);
      if (bus.rsp_valid || bus.timx_psel) saw = 1'b1;
    end
    check("t1_no_rsp", 32'(saw), 32'(0));
    check("t1_idle_busy", 32'(bus.busy), 32'(0));
    tick();

    // stuck slave
    slv_stuck = 1'b1;
    bus.rsp_ready = 1'b0;
    send(1'b1, 16'h0020, 32'hCAFEF00D);
    wait_penable();
`ifdef APB_TIMEOUT_EN
    n = 0;
    while (bus.timx_penable && n < 100) begin
      n++;
      @(negedge apb_clk);
    end
    check("t6_access_cycles", 32'(n), 32'(TMO));
    check("t6_psel", 32'(bus.timx_psel), 32'(0));
    check("t6_rspv", 32'(bus.rsp_valid), 32'(1));
    check("t6_err", 32'(bus.rsp_err), 32'(1));
    check("t6_tmo", 32'(bus.rsp_timeout), 32'(1));
    check("t6_rdata", bus.rsp_rdata, 32'h0);
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    slv_stuck = 1'b0;
`else
    repeat (1000) @(negedge apb_clk);
    check("t6_psel", 32'(bus.timx_psel), 32'(1));
    check("t6_pen", 32'(bus.timx_penable), 32'(1));
    check("t6_rspv", 32'(bus.rsp_valid), 32'(0));
    check("t6_busy", 32'(bus.busy), 32'(1));
    tick();
    apb_rst_n = 1'b0;
    tick();
    apb_rst_n = 1'b1;
    slv_stuck = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
`endif
    drain(50);

    // random traffic against the reference model
    qc.delete();
    qr.delete();
    sb_en = 1'b1;
    slv_rand = 1'b1;
    base = rsp_cnt;
    idx = 0;
    cyc = 0;
    while (idx < 150 && cyc < 4000) begin
      n = $urandom_range(0, 19);
      bus.cmd_valid = ($urandom_range(0, 3) != 0);
      bus.cmd_write = 1'($urandom_range(0, 1));
      bus.cmd_addr  = (n < 16) ? 16'(n * 4)
                    : 16'(16'h0100 + n * 4);
      bus.cmd_wdata = $urandom;
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge apb_clk);
      acc = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    check("rand_accepted", 32'(idx), 32'(150));
    drain(500);
    check("rand_rsp_count", 32'(rsp_cnt - base), 32'(idx));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
